// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_pkg                                                      |
// | Description : Shared constants and types for the PS/2 key event receiver.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ps2_pkg;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_REL = 8'hF0;

    // Event word layout: {extended, release, code[7:0]}
    localparam int EV_W        = 10;
    localparam int EV_CODE_LSB = 0;
    localparam int EV_CODE_MSB = 7;
    localparam int EV_REL_BIT  = 8;
    localparam int EV_EXT_BIT  = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_event_fifo                                               |
// | Description : First-word fall-through FIFO with fill count and sticky      |
// |               overflow flag.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             overflow_q;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == FULL_CNT);
    assign w_pop   = ready_i & ~w_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push  = push_i & (~w_full | w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_i && w_full && !w_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign valid_o    = ~w_empty;
    assign data_o     = w_empty ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: rtl/ps2_key_event_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_key_event_rx                                             |
// | Description : PS/2 keyboard receiver: sync, clock de-glitch, framing,      |
// |               E0/F0 prefix folding and a key event FIFO.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clock50,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_extended,
    output logic                          ev_release,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic filt_q, filt_prev_q;
    logic [FW-1:0] filt_cnt_q;
    logic w_fall;

    always_ff @(posedge clock50) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            dat_meta_q  <= 1'b1;
            dat_sync_q  <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            dat_meta_q  <= ps2_data;
            dat_sync_q  <= dat_meta_q;
            filt_prev_q <= filt_q;
            // Any sample agreeing with the current level restarts the run.
            if (clk_sync_q == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_q     <= clk_sync_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    assign w_fall = filt_prev_q & ~filt_q;

    frame_state_e    state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_ok_q, par_ok_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            byte_valid_q, byte_valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge clock50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        tmo_d        = '0;
        byte_valid_d = 1'b0;
        perr_d       = 1'b0;
        ferr_d       = 1'b0;
        if (w_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_ok_d = ^{shift_q, dat_sync_q};
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!dat_sync_q) begin
                        ferr_d = 1'b1;
                    end else if (!par_ok_q) begin
                        perr_d = 1'b1;
                    end else begin
                        byte_valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                ferr_d  = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    logic            ext_q, rel_q;
    logic            push_q;
    logic [EV_W-1:0] push_data_q;

    always_ff @(posedge clock50) begin
        if (reset) begin
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (perr_q || ferr_q) begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end else if (byte_valid_q) begin
                if (shift_q == PREFIX_EXT) begin
                    ext_q <= 1'b1;
                end else if (shift_q == PREFIX_REL) begin
                    rel_q <= 1'b1;
                end else begin
                    push_q      <= 1'b1;
                    push_data_q <= {ext_q, rel_q, shift_q};
                    ext_q       <= 1'b0;
                    rel_q       <= 1'b0;
                end
            end
        end
    end

    logic [EV_W-1:0] w_head;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk_i       (clock50),
        .rst_i       (reset),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .ready_i     (ev_ready),
        .valid_o     (ev_valid),
        .data_o      (w_head),
        .count_o     (ev_count),
        .overflow_o  (overflow)
    );

    assign ev_code     = w_head[EV_CODE_MSB:EV_CODE_LSB];
    assign ev_release  = w_head[EV_REL_BIT];
    assign ev_extended = w_head[EV_EXT_BIT];
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ps2_key_event_rx                                          |
// | Description : Directed, table-driven bench for ps2_key_event_rx.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ps2_key_event_rx;

    localparam int DEPTH = 4;
    localparam int F     = 4;
    localparam int TMO   = 300;
    localparam int H     = 20;
    // Negedge index (after the stop-bit clock falls) where error/valid pulses sit
    localparam int K     = 3 + F;

    logic       clock50 = 1'b0;
    logic       reset   = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_code;
    logic       ev_extended;
    logic       ev_release;
    logic [2:0] ev_count;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;

    ps2_key_event_rx #(
        .FIFO_DEPTH     (DEPTH),
        .FILTER_LEN     (F),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock50     (clock50),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_code     (ev_code),
        .ev_extended (ev_extended),
        .ev_release  (ev_release),
        .ev_count    (ev_count),
        .overflow    (overflow),
        .parity_err  (parity_err),
        .frame_err   (frame_err)
    );

    always #5 clock50 = ~clock50;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic tr_perr [0:2*H];
    logic tr_ferr [0:2*H];
    int   tr_cnt  [0:2*H];

    typedef struct {
        logic [7:0] b;
        bit         pflip;
        bit         stopb;
        bit         eperr;
        bit         eferr;
        int         ecnt;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_bit(input logic b, input bit rec, input int pop_at);
        ps2_data = b;
        repeat (H) @(negedge clock50);
        ps2_clk = 1'b0;
        for (int k = 1; k <= 2*H; k++) begin
            @(negedge clock50);
            if (rec) begin
                tr_perr[k] = parity_err;
                tr_ferr[k] = frame_err;
                tr_cnt[k]  = int'(ev_count);
            end
            if (k == pop_at)     ev_ready = 1'b1;
            if (k == pop_at + 1) ev_ready = 1'b0;
            if (k == H)          ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pflip, input bit stopb,
                              input int pop_at);
        logic p;
        p = ~(^b) ^ pflip;
        drive_bit(1'b0, 1'b0, -10);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 1'b0, -10);
        drive_bit(p, 1'b0, -10);
        drive_bit(stopb, 1'b1, pop_at);
        ps2_data = 1'b1;
    endtask

    function automatic int head();
        return int'({ev_extended, ev_release, ev_code});
    endfunction

    task automatic pop_expect(input string name, input int exp_ev, input int cnt_before);
        check({name, "_valid"}, int'(ev_valid), 1);
        check({name, "_head"}, head(), exp_ev);
        check({name, "_cnt"}, int'(ev_count), cnt_before);
        ev_ready = 1'b1;
        @(negedge clock50);
        ev_ready = 1'b0;
        check({name, "_cnt_after"}, int'(ev_count), cnt_before - 1);
    endtask

    vec_t vecs[12];

    initial begin
        int prev_cnt;
        int hi;
        int rises;
        logic prev;

        vecs[0]  = '{8'h1C, 0, 1, 0, 0, 1};
        vecs[1]  = '{8'hF0, 0, 1, 0, 0, 1};
        vecs[2]  = '{8'h1C, 0, 1, 0, 0, 2};
        vecs[3]  = '{8'hE0, 0, 1, 0, 0, 2};
        vecs[4]  = '{8'hF0, 0, 1, 0, 0, 2};
        vecs[5]  = '{8'h75, 0, 1, 0, 0, 3};
        vecs[6]  = '{8'hE0, 0, 1, 0, 0, 3};
        vecs[7]  = '{8'h1C, 1, 1, 1, 0, 3};
        vecs[8]  = '{8'hF0, 0, 1, 0, 0, 3};
        vecs[9]  = '{8'h5A, 0, 0, 0, 1, 3};
        vecs[10] = '{8'h44, 1, 0, 0, 1, 3};
        vecs[11] = '{8'h32, 0, 1, 0, 0, 4};

        repeat (5) @(negedge clock50);
        reset = 1'b0;
        @(negedge clock50);
        check("rst_valid", int'(ev_valid), 0);
        check("rst_count", int'(ev_count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_perr", int'(parity_err), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_head", head(), 0);

        prev_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i].b, vecs[i].pflip, vecs[i].stopb, -10);
            check($sformatf("v%0d_perr_pre", i), int'(tr_perr[K-1]), 0);
            check($sformatf("v%0d_perr", i), int'(tr_perr[K]), int'(vecs[i].eperr));
            check($sformatf("v%0d_perr_post", i), int'(tr_perr[K+1]), 0);
            check($sformatf("v%0d_ferr_pre", i), int'(tr_ferr[K-1]), 0);
            check($sformatf("v%0d_ferr", i), int'(tr_ferr[K]), int'(vecs[i].eferr));
            check($sformatf("v%0d_ferr_post", i), int'(tr_ferr[K+1]), 0);
            check($sformatf("v%0d_cnt_c2", i), tr_cnt[K+1], prev_cnt);
            check($sformatf("v%0d_cnt_c3", i), tr_cnt[K+2], vecs[i].ecnt);
            prev_cnt = vecs[i].ecnt;
        end
        pop_expect("tbl_ev0", 10'h01C, 4);
        pop_expect("tbl_ev1", 10'h11C, 3);
        pop_expect("tbl_ev2", 10'h375, 2);
        pop_expect("tbl_ev3", 10'h032, 1);
        check("empty_valid", int'(ev_valid), 0);
        check("empty_head", head(), 0);
        check("pop_on_empty_cnt", int'(ev_count), 0);

        // Overflow: fill, drop one, then a push that coincides with a pop.
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 0, 1, -10);
        check("ovf_cnt_full", int'(ev_count), 4);
        check("ovf_not_yet", int'(overflow), 0);
        send_frame(8'h15, 0, 1, -10);
        check("ovf_cnt_drop", int'(ev_count), 4);
        check("ovf_set", int'(overflow), 1);
        check("ovf_head", head(), 10'h011);
        send_frame(8'h16, 0, 1, 4 + F);
        check("ovf_pushpop_cnt", tr_cnt[K+2], 4);
        check("ovf_pushpop_head", head(), 10'h012);
        check("ovf_sticky", int'(overflow), 1);
        pop_expect("ovf_ev0", 10'h012, 4);
        pop_expect("ovf_ev1", 10'h013, 3);
        pop_expect("ovf_ev2", 10'h014, 2);
        pop_expect("ovf_ev3", 10'h016, 1);

        // Timeout: start bit plus four data bits, then the clock stops.
        drive_bit(1'b0, 1'b0, -10);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, -10);
        ps2_data = 1'b1;
        hi = 0;
        rises = 0;
        prev = 1'b0;
        for (int k = 0; k < TMO + 100; k++) begin
            @(negedge clock50);
            if (frame_err) hi++;
            if (frame_err && !prev) rises++;
            prev = frame_err;
        end
        check("tmo_pulses", rises, 1);
        check("tmo_width", hi, 1);
        check("tmo_no_event", int'(ev_count), 0);
        send_frame(8'h29, 0, 1, -10);
        check("tmo_next_cnt", tr_cnt[K+2], 1);
        pop_expect("tmo_ev", 10'h029, 1);

        // Reset mid-frame with E0 pending and two events queued.
        send_frame(8'h16, 0, 1, -10);
        send_frame(8'h1E, 0, 1, -10);
        send_frame(8'hE0, 0, 1, -10);
        check("rst2_cnt_before", int'(ev_count), 2);
        drive_bit(1'b0, 1'b0, -10);
        drive_bit(1'b1, 1'b0, -10);
        drive_bit(1'b0, 1'b0, -10);
        reset = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clock50);
        reset = 1'b0;
        @(negedge clock50);
        check("rst2_valid", int'(ev_valid), 0);
        check("rst2_cnt", int'(ev_count), 0);
        check("rst2_overflow", int'(overflow), 0);
        check("rst2_head", head(), 0);
        send_frame(8'h74, 0, 1, -10);
        check("rst2_ferr", int'(tr_ferr[K]), 0);
        check("rst2_next_cnt", tr_cnt[K+2], 1);
        pop_expect("rst2_ev", 10'h074, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver: synchronises and de-glitches the raw PS/2 clock/data lines, frames and checks 11-bit device-to-host packets, folds E0/F0 prefix bytes into decoded key events, and buffers the events in a FIFO with a valid/ready read port. It replaces the fixed keyboard/oneshot pairing at the top level: consumers pop whole key events instead of polling raw scan bytes.

## Interface
Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 100000: clock50 cycles without a filtered falling edge, mid-frame, before the frame is aborted (2 ms at 50 MHz).

Ports:
- clock50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts head; pop on ev_valid & ev_ready.
- ev_code  out  8  scan code of head event.
- ev_extended  out  1  head event was E0-prefixed.
- ev_release  out  1  head event was F0-prefixed (key up).
- ev_count  out  $clog2(FIFO_DEPTH)+1  entries stored.
- overflow  out  1  sticky: an event was dropped on full FIFO.
- parity_err  out  1  one-cycle pulse: frame discarded on bad parity.
- frame_err  out  1  one-cycle pulse: bad stop bit or timeout.

## Operation
- Both lines pass through a 2-FF synchroniser. Clock filter: counter of identical samples; filtered level updates when FILTER_LEN agree. Data is not filtered.
- Frame FSM, advanced only on filtered clk falling edge: IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
  - IDLE: data=0 starts frame; data=1 is ignored, stays IDLE.
  - PARITY: odd parity over 8 data bits + parity bit.
  - STOP: data=1 and parity good → byte_valid pulse. Parity bad → parity_err pulse. Stop=0 → frame_err pulse (takes priority over parity_err). Always returns to IDLE.
  - Timeout: in any state other than IDLE, TIMEOUT_CYCLES cycles with no falling edge → IDLE, frame_err pulse, partial byte discarded. Counter clears on every falling edge.
- Decoder holds ext and rel flags:
  - byte 8'hE0 → ext=1, no event. byte 8'hF0 → rel=1, no event.
  - any other byte (incl. E1, AA, FA) → push {ext, rel, byte}; clear both flags.
  - parity_err or frame_err clears both flags.
- FIFO: 10-bit entries {extended, release, code}, first-word fall-through.
  - Push when not full, or when full and a pop occurs the same cycle (accepted).
  - Push when full without pop → event dropped, overflow set; it clears only on reset.
  - Pop on empty is ignored. Simultaneous push/pop on empty is impossible (ev_valid=0).
  - Read/write pointers wrap at FIFO_DEPTH; ev_count = 0..FIFO_DEPTH.
- Reset (any cycle, incl. mid-frame): FSM→IDLE, filtered clk→1, flags clear, FIFO empty, timeout counter 0. All outputs 0 after reset; ev_code/ev_extended/ev_release read 0 while empty.

## Timing
- Filtered clk edge lags raw pin edge by 2 + FILTER_LEN cycles.
- Cycle c: filtered falling edge sampling stop bit. c+1: byte_valid / error pulse. c+2: decoder pushes. c+3: ev_valid=1, ev_count incremented.
- Pop at cycle p: ev_count decrements and next head presented at p+1.
- Error pulses are exactly one cycle wide.

## Structure
- Shared package ps2_pkg: PREFIX_EXT=8'hE0, PREFIX_REL=8'hF0, event width (10), frame FSM state encoding, event field bit positions.
- One sub-module: ps2_event_fifo (parametrised depth/width FWFT FIFO with count and overflow). Synchroniser, filter, frame FSM and decoder stay in the top module.

## Test plan
- Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) → one event code=0x1C, ext=0, rel=0; ev_valid at c+3.
- Bytes F0,1C then E0,F0,75 → two events: {0,1,0x1C}, {1,1,0x75}; ev_count=2.
- Frame 0x1C with parity bit 1 → parity_err one pulse, no event; following F0-less byte 0x32 → {0,0,0x32}.
- FIFO_DEPTH=4, five events, ev_ready=0 → ev_count=4, overflow=1, head=first event; then pop with push same cycle when full → no further drop.
- Stop clock after 4 data bits for TIMEOUT_CYCLES → frame_err pulse, FSM IDLE; next full frame 0x29 decodes correctly.
- Assert reset mid-frame with E0 pending and 2 events queued → ev_valid=0, ev_count=0, overflow=0; next frame 0x74 → {0,0,0x74} (ext cleared).
